// File: rtl/e_mdu_if.sv
// Operand/result bundle between the E-stage pipeline and the multiply/divide unit.
// The pipeline side uses the master modport; the MDU uses the slave modport.
interface e_mdu_if;
  logic        start;
  logic [3:0]  mdop;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start,
    output mdop,
    output rs_val,
    output rt_val,
    output flush,
    input  busy,
    input  hi,
    input  lo
  );

  modport slave (
    input  start,
    input  mdop,
    input  rs_val,
    input  rt_val,
    input  flush,
    output busy,
    output hi,
    output lo
  );
endinterface

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: multi-cycle mult/div plus mthi/mtlo over internal HI/LO.
// Optional madd/maddu/msub/msubu are enabled by defining MDU_MADD_EN.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic    clk,
  input logic    reset,
  e_mdu_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e      state_q;
  logic [31:0] cnt_q;
  logic        busy_q;
  logic        commit_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [63:0] pend_q;

  // Opcode decode
  logic mul_op;
  logic div_op;
  logic mthi_op;
  logic mtlo_op;
  logic sgn_op;
`ifdef MDU_MADD_EN
  logic acc_op;
  logic sub_op;
`endif

  always_comb begin
    mul_op  = 1'b0;
    div_op  = 1'b0;
    mthi_op = 1'b0;
    mtlo_op = 1'b0;
    sgn_op  = 1'b0;
`ifdef MDU_MADD_EN
    acc_op  = 1'b0;
    sub_op  = 1'b0;
`endif
    case (bus.mdop)
      4'd1: begin mul_op = 1'b1; sgn_op = 1'b1; end
      4'd2: mul_op = 1'b1;
      4'd3: begin div_op = 1'b1; sgn_op = 1'b1; end
      4'd4: div_op = 1'b1;
      4'd5: mthi_op = 1'b1;
      4'd6: mtlo_op = 1'b1;
`ifdef MDU_MADD_EN
      4'd7:  begin mul_op = 1'b1; acc_op = 1'b1; sgn_op = 1'b1; end
      4'd8:  begin mul_op = 1'b1; acc_op = 1'b1; end
      4'd9:  begin mul_op = 1'b1; acc_op = 1'b1; sub_op = 1'b1; sgn_op = 1'b1; end
      4'd10: begin mul_op = 1'b1; acc_op = 1'b1; sub_op = 1'b1; end
`endif
      default: ;
    endcase
  end

  logic idle;
  logic go;
  assign idle = (state_q == StIdle);
  assign go   = bus.start & ~bus.flush & idle;

  // Multiply: sign/zero-extend to 64 bits so a single 64-bit product serves both forms.
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod;
  logic [63:0] mul_res;

  assign mul_a = {{32{sgn_op & bus.rs_val[31]}}, bus.rs_val};
  assign mul_b = {{32{sgn_op & bus.rt_val[31]}}, bus.rt_val};
  assign prod  = mul_a * mul_b;

`ifdef MDU_MADD_EN
  logic [63:0] acc_res;
  assign acc_res = sub_op ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
  assign mul_res = acc_op ? acc_res : prod;
`else
  assign mul_res = prod;
`endif

  // Divide on magnitudes so that 0x80000000 / -1 needs no special case.
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] divisor;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        div_zero;

  assign a_neg    = sgn_op & bus.rs_val[31];
  assign b_neg    = sgn_op & bus.rt_val[31];
  assign a_mag    = a_neg ? (32'd0 - bus.rs_val) : bus.rs_val;
  assign b_mag    = b_neg ? (32'd0 - bus.rt_val) : bus.rt_val;
  assign div_zero = (bus.rt_val == 32'd0);
  assign divisor  = div_zero ? 32'd1 : b_mag;
  assign q_mag    = a_mag / divisor;
  assign r_mag    = a_mag % divisor;
  assign quot     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem      = a_neg ? (32'd0 - r_mag) : r_mag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= 32'd0;
      busy_q   <= 1'b0;
      commit_q <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      pend_q   <= 64'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (go && mul_op) begin
            state_q  <= StMul;
            cnt_q    <= MULT_CYCLES;
            busy_q   <= 1'b1;
            commit_q <= 1'b1;
            pend_q   <= mul_res;
          end else if (go && div_op) begin
            state_q  <= StDiv;
            cnt_q    <= DIV_CYCLES;
            busy_q   <= 1'b1;
            commit_q <= ~div_zero;
            pend_q   <= {rem, quot};
          end else if (go && mthi_op) begin
            hi_q <= bus.rs_val;
          end else if (go && mtlo_op) begin
            lo_q <= bus.rs_val;
          end
        end
        StMul, StDiv: begin
          if (cnt_q <= 32'd1) begin
            state_q <= StIdle;
            cnt_q   <= 32'd0;
            busy_q  <= 1'b0;
            if (commit_q) begin
              hi_q <= pend_q[63:32];
              lo_q <= pend_q[31:0];
            end
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu; define MDU_MADD_EN to cover the accumulate ops.
module tb_e_mdu;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  e_mdu_if bus ();

  e_mdu #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge: drives one start cycle and returns at the next negedge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic fl);
    bus.start  = 1'b1;
    bus.mdop   = op;
    bus.rs_val = a;
    bus.rt_val = b;
    bus.flush  = fl;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.mdop   = 4'd0;
    bus.flush  = 1'b0;
  endtask

  // Counts negedges with busy high; returns at the first negedge with busy low.
  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_cycles(3);
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    vectors++;
    if (bus.hi !== 32'd0) begin
      miscompares++; $display("FAIL reset_hi: got %h want 00000000", bus.hi);
    end
    vectors++;
    if (bus.lo !== 32'd0) begin
      miscompares++; $display("FAIL reset_lo: got %h want 00000000", bus.lo);
    end
    reset = 1'b1;
    idle_cycles(1);
  endtask

  task automatic test_mult();
    int n;
    issue(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    wait_idle(n);
    vectors++;
    if (n !== 5) begin miscompares++; $display("FAIL mult_busy: got %0d want 5", n); end
    vectors++;
    if (bus.hi !== 32'hFFFF_FFFF) begin
      miscompares++; $display("FAIL mult_hi: got %h want ffffffff", bus.hi);
    end
    vectors++;
    if (bus.lo !== 32'hFFFF_FFFA) begin
      miscompares++; $display("FAIL mult_lo: got %h want fffffffa", bus.lo);
    end
    issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_idle(n);
    vectors++;
    if (n !== 5) begin miscompares++; $display("FAIL multu_busy: got %0d want 5", n); end
    vectors++;
    if ({bus.hi, bus.lo} !== 64'hFFFF_FFFE_0000_0001) begin
      miscompares++;
      $display("FAIL multu_res: got %h%h want fffffffe00000001", bus.hi, bus.lo);
    end
  endtask

  task automatic test_div();
    int n;
    issue(4'd4, 32'd7, 32'd2, 1'b0);
    wait_idle(n);
    vectors++;
    if (n !== 10) begin miscompares++; $display("FAIL divu_busy: got %0d want 10", n); end
    vectors++;
    if ({bus.hi, bus.lo} !== {32'd1, 32'd3}) begin
      miscompares++; $display("FAIL divu_res: got %h/%h want 00000001/00000003", bus.hi, bus.lo);
    end
    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle(n);
    vectors++;
    if (n !== 10) begin miscompares++; $display("FAIL div_busy: got %0d want 10", n); end
    vectors++;
    if ({bus.hi, bus.lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      miscompares++; $display("FAIL div_res: got %h/%h want ffffffff/fffffffd", bus.hi, bus.lo);
    end
  endtask

  task automatic test_div_edge();
    int n;
    issue(4'd5, 32'h0000_1234, 32'd0, 1'b0);
    vectors++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'h0000_1234) begin
      miscompares++; $display("FAIL mthi: got busy=%b hi=%h want busy=0 hi=00001234",
                              bus.busy, bus.hi);
    end
    issue(4'd3, 32'd100, 32'd0, 1'b0);
    wait_idle(n);
    vectors++;
    if (n !== 10) begin miscompares++; $display("FAIL div0_busy: got %0d want 10", n); end
    vectors++;
    if ({bus.hi, bus.lo} !== {32'h0000_1234, 32'hFFFF_FFFD}) begin
      miscompares++; $display("FAIL div0_keep: got %h/%h want 00001234/fffffffd", bus.hi, bus.lo);
    end
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle(n);
    vectors++;
    if ({bus.hi, bus.lo} !== {32'd0, 32'h8000_0000}) begin
      miscompares++; $display("FAIL div_ovf: got %h/%h want 00000000/80000000", bus.hi, bus.lo);
    end
  endtask

  task automatic test_flush();
    issue(4'd1, 32'd5, 32'd7, 1'b1);
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++; $display("FAIL flush_busy: got %b want 0", bus.busy);
    end
    idle_cycles(7);
    vectors++;
    if ({bus.hi, bus.lo} !== {32'd0, 32'h8000_0000}) begin
      miscompares++; $display("FAIL flush_mult: got %h/%h want 00000000/80000000", bus.hi, bus.lo);
    end
    issue(4'd6, 32'h0000_AAAA, 32'd0, 1'b1);
    vectors++;
    if (bus.lo !== 32'h8000_0000) begin
      miscompares++; $display("FAIL flush_mtlo: got %h want 80000000", bus.lo);
    end
    issue(4'd6, 32'h0000_AAAA, 32'd0, 1'b0);
    vectors++;
    if (bus.lo !== 32'h0000_AAAA) begin
      miscompares++; $display("FAIL mtlo: got %h want 0000aaaa", bus.lo);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    issue(4'd1, 32'd2, 32'd3, 1'b0);
    issue(4'd5, 32'h0000_DEAD, 32'd0, 1'b0);
    wait_idle(n);
    vectors++;
    if (n !== 4) begin miscompares++; $display("FAIL b2b_busy1: got %0d want 4", n); end
    vectors++;
    if ({bus.hi, bus.lo} !== {32'd0, 32'd6}) begin
      miscompares++; $display("FAIL mthi_busy: got %h/%h want 00000000/00000006", bus.hi, bus.lo);
    end
    issue(4'd4, 32'd6, 32'd4, 1'b0);
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++; $display("FAIL b2b_accept: got %b want 1", bus.busy);
    end
    wait_idle(n);
    vectors++;
    if (n !== 10 || {bus.hi, bus.lo} !== {32'd2, 32'd1}) begin
      miscompares++; $display("FAIL b2b_divu: got n=%0d %h/%h want n=10 00000002/00000001",
                              n, bus.hi, bus.lo);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    issue(4'd1, 32'h10, 32'h10, 1'b0);
    idle_cycles(2);
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      miscompares++; $display("FAIL reset_mid: got busy=%b %h/%h want busy=0 00000000/00000000",
                              bus.busy, bus.hi, bus.lo);
    end
    @(negedge clk);
    reset = 1'b1;
    idle_cycles(10);
    wait_idle(n);
    vectors++;
    if (bus.lo !== 32'd0 || bus.hi !== 32'd0) begin
      miscompares++; $display("FAIL reset_nocommit: got %h/%h want 00000000/00000000",
                              bus.hi, bus.lo);
    end
  endtask

  task automatic test_madd();
    int n;
    issue(4'd5, 32'd0, 32'd0, 1'b0);
    issue(4'd6, 32'd5, 32'd0, 1'b0);
    issue(4'd7, 32'd2, 32'd3, 1'b0);
`ifdef MDU_MADD_EN
    wait_idle(n);
    vectors++;
    if (n !== 5 || {bus.hi, bus.lo} !== {32'd0, 32'd11}) begin
      miscompares++; $display("FAIL madd: got n=%0d %h/%h want n=5 00000000/0000000b",
                              n, bus.hi, bus.lo);
    end
    issue(4'd9, 32'd4, 32'd3, 1'b0);
    wait_idle(n);
    vectors++;
    if ({bus.hi, bus.lo} !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      miscompares++; $display("FAIL msub: got %h/%h want ffffffff/ffffffff", bus.hi, bus.lo);
    end
    issue(4'd8, 32'd1, 32'd1, 1'b0);
    wait_idle(n);
    vectors++;
    if ({bus.hi, bus.lo} !== 64'd0) begin
      miscompares++; $display("FAIL maddu_wrap: got %h/%h want 00000000/00000000", bus.hi, bus.lo);
    end
`else
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++; $display("FAIL madd_off_busy: got %b want 0", bus.busy);
    end
    idle_cycles(6);
    wait_idle(n);
    vectors++;
    if ({bus.hi, bus.lo} !== {32'd0, 32'd5}) begin
      miscompares++; $display("FAIL madd_off_keep: got %h/%h want 00000000/00000005",
                              bus.hi, bus.lo);
    end
`endif
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    bus.start   = 1'b0;
    bus.mdop    = 4'd0;
    bus.rs_val  = 32'd0;
    bus.rt_val  = 32'd0;
    bus.flush   = 1'b0;
    @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_div_edge();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_madd();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish before 200000");
    $fatal(1);
  end
endmodule
